multicycle_ctrl: RTL and testbench

Control FSM that sequences a shared-resource multicycle RV32I datapath: one ALU, one unified instruction/data memory, and one register file. These are reused across fetch, decode, execute, memory and writeback steps. The block issues mux selects, write strobes and ALU control from the instruction fields, and stalls on a memory ready handshake. It replaces the per-cycle combinational control of the single-cycle core.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle control FSM and the shared datapath.
// The controller (master) drives the strobes and selects. The datapath (slave) supplies instruction fields and flags.
interface multicycle_ctrl_if #(
   parameter int ST_W = 4
);
   logic [6:0]      op;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic            zero;
   logic            mem_ready;
   logic            PCWrite;
   logic            AdrSrc;
   logic            MemWrite;
   logic            IRWrite;
   logic [1:0]      ResultSrc;
   logic [1:0]      ALUSrcA;
   logic [1:0]      ALUSrcB;
   logic [2:0]      ALUControl;
   logic [1:0]      ImmSrc;
   logic            RegWrite;
   logic            instr_retire;
   logic            illegal_instr;
   logic [ST_W-1:0] state_o;

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, instr_retire, illegal_instr, state_o
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, instr_retire, illegal_instr, state_o
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I core with a shared ALU, memory and register file.
// It sequences fetch, decode, execute, memory and writeback, and it stalls on mem_ready.
module multicycle_ctrl #(
   parameter int ST_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);
   localparam logic [ST_W-1:0] S_FETCH    = ST_W'(0);
   localparam logic [ST_W-1:0] S_DECODE   = ST_W'(1);
   localparam logic [ST_W-1:0] S_MEMADR   = ST_W'(2);
   localparam logic [ST_W-1:0] S_MEMREAD  = ST_W'(3);
   localparam logic [ST_W-1:0] S_MEMWB    = ST_W'(4);
   localparam logic [ST_W-1:0] S_MEMWRITE = ST_W'(5);
   localparam logic [ST_W-1:0] S_EXECR    = ST_W'(6);
   localparam logic [ST_W-1:0] S_EXECI    = ST_W'(7);
   localparam logic [ST_W-1:0] S_ALUWB    = ST_W'(8);
   localparam logic [ST_W-1:0] S_BEQ      = ST_W'(9);
   localparam logic [ST_W-1:0] S_JAL      = ST_W'(10);
   localparam logic [ST_W-1:0] S_ILLEGAL  = ST_W'(11);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] AOP_ADD   = 2'd0;
   localparam logic [1:0] AOP_SUB   = 2'd1;
   localparam logic [1:0] AOP_FUNCT = 2'd2;

   function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                             input logic is_rtype, input logic f7b5);
      logic [2:0] ctl;
      ctl = 3'b000;
      if (alu_op == AOP_SUB) begin
         ctl = 3'b001;
      end else if (alu_op == AOP_FUNCT) begin
         case (f3)
            3'b000:  ctl = (is_rtype && f7b5) ? 3'b001 : 3'b000; // addi ignores instr[30]
            3'b010:  ctl = 3'b101;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
         endcase
      end
      return ctl;
   endfunction

   logic [ST_W-1:0] state_q, state_d;
   logic            illegal_q, illegal_d;
   logic [1:0]      alu_op;
   logic            pc_write, mem_write, ir_write, reg_write, retire;

   always_comb begin
      state_d           = state_q;
      alu_op            = AOP_ADD;
      pc_write          = 1'b0;
      mem_write         = 1'b0;
      ir_write          = 1'b0;
      reg_write         = 1'b0;
      retire            = 1'b0;
      bus.AdrSrc        = 1'b0;
      bus.ResultSrc     = 2'b00;
      bus.ALUSrcA       = 2'b00;
      bus.ALUSrcB       = 2'b00;
      case (state_q)
         S_FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            pc_write      = bus.mem_ready;
            ir_write      = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            bus.ResultSrc = 2'b01;
            reg_write     = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            bus.AdrSrc = 1'b1;
            mem_write  = 1'b1;
            retire     = bus.mem_ready;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            bus.ALUSrcA = 2'b10;
            alu_op      = AOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            alu_op      = AOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            bus.ALUSrcA = 2'b10;
            alu_op      = AOP_SUB;
            pc_write    = bus.zero;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_JAL: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pc_write    = 1'b1;
            state_d     = S_ALUWB; // ALUWB writes PC+4 into rd
         end
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase
      illegal_d = illegal_q | (state_q == S_ILLEGAL);
   end

   always_comb begin
      case (bus.op)
         OP_SW:   bus.ImmSrc = 2'b01;
         OP_BEQ:  bus.ImmSrc = 2'b10;
         OP_JAL:  bus.ImmSrc = 2'b11;
         default: bus.ImmSrc = 2'b00;
      endcase
   end

   // Architectural strobes are gated during reset so that the reset cycle makes no partial writes.
   assign bus.PCWrite       = pc_write  & ~rst;
   assign bus.MemWrite      = mem_write & ~rst;
   assign bus.IRWrite       = ir_write  & ~rst;
   assign bus.RegWrite      = reg_write & ~rst;
   assign bus.instr_retire  = retire    & ~rst;
   assign bus.ALUControl    = alu_decode(alu_op, bus.funct3, bus.op == OP_R, bus.funct7b5);
   assign bus.illegal_instr = illegal_q;
   assign bus.state_o       = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: a per-instruction step model queues expected outputs.
// A negedge monitor checks those queued outputs against the DUT.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.ST_W(4)) bus ();
   multicycle_ctrl #(.ST_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   typedef struct packed {
      logic       pcw, adr, mw, irw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu;
      logic [1:0] imm;
      logic       rw, ret, ill;
   } exp_t;

   typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL} kind_e;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic [6:0] cur_op  = 7'b0110011;
   logic [2:0] cur_f3  = 3'b000;
   logic       cur_f7  = 1'b0;
   logic       ill_exp = 1'b0;
   exp_t mon_e, mon_a;

   function automatic logic rb();
      return 1'($urandom & 1);
   endfunction

   function automatic exp_t base();
      exp_t e;
      e     = '0;
      e.ill = ill_exp;
      case (cur_op)
         7'b0100011: e.imm = 2'b01;
         7'b1100011: e.imm = 2'b10;
         7'b1101111: e.imm = 2'b11;
         default:    e.imm = 2'b00;
      endcase
      return e;
   endfunction

   function automatic logic [2:0] ref_alu();
      case (cur_f3)
         3'b000:  return (cur_op == 7'b0110011 && cur_f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic step(input exp_t e, input logic rdy, input logic z, input logic r);
      @(posedge clk);
      #1;
      rst           = r;
      bus.op        = cur_op;
      bus.funct3    = cur_f3;
      bus.funct7b5  = cur_f7;
      bus.mem_ready = rdy;
      bus.zero      = z;
      q.push_back(e);
   endtask

   task automatic fetch(input int stalls);
      exp_t e;
      e = base(); e.sb = 2'b10; e.rs = 2'b10;
      repeat (stalls) step(e, 1'b0, rb(), 1'b0);
      e.pcw = 1'b1; e.irw = 1'b1;
      step(e, 1'b1, rb(), 1'b0);
   endtask

   task automatic alu_wb();
      exp_t e;
      e = base(); e.rw = 1'b1; e.ret = 1'b1;
      step(e, rb(), rb(), 1'b0);
   endtask

   task automatic mem_adr();
      exp_t e;
      e = base(); e.sa = 2'b10; e.sb = 2'b01;
      step(e, rb(), rb(), 1'b0);
   endtask

   // One instruction, start to retire; mstall cycles of mem_ready=0 in the memory-wait state.
   task automatic run_instr(input kind_e k, input int fstall, input int mstall);
      exp_t e;
      logic z;
      case (k)
         K_R:     cur_op = 7'b0110011;
         K_I:     cur_op = 7'b0010011;
         K_LW:    cur_op = 7'b0000011;
         K_SW:    cur_op = 7'b0100011;
         K_BEQ:   cur_op = 7'b1100011;
         default: cur_op = 7'b1101111;
      endcase
      cur_f3 = 3'($urandom);
      cur_f7 = rb();
      fetch(fstall);
      e = base(); e.sa = 2'b01; e.sb = 2'b01;
      step(e, rb(), rb(), 1'b0);
      case (k)
         K_R, K_I: begin
            e = base(); e.sa = 2'b10; e.sb = (k == K_I) ? 2'b01 : 2'b00; e.alu = ref_alu();
            step(e, rb(), rb(), 1'b0);
            alu_wb();
         end
         K_LW: begin
            mem_adr();
            e = base(); e.adr = 1'b1;
            repeat (mstall) step(e, 1'b0, rb(), 1'b0);
            step(e, 1'b1, rb(), 1'b0);
            e = base(); e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
            step(e, rb(), rb(), 1'b0);
         end
         K_SW: begin
            mem_adr();
            e = base(); e.adr = 1'b1; e.mw = 1'b1;
            repeat (mstall) step(e, 1'b0, rb(), 1'b0);
            e.ret = 1'b1;
            step(e, 1'b1, rb(), 1'b0);
         end
         K_BEQ: begin
            z = rb();
            e = base(); e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.ret = 1'b1;
            step(e, rb(), z, 1'b0);
         end
         default: begin
            e = base(); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
            step(e, rb(), rb(), 1'b0);
            alu_wb();
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         mon_a = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegWrite,
                  bus.instr_retire, bus.illegal_instr};
         total++;
         if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL ctrl_outputs t=%0t op=%b f3=%b f7=%b got=%b want=%b (pcw,adr,mw,irw,rs,sa,sb,alu,imm,rw,ret,ill)",
                     $time, bus.op, bus.funct3, bus.funct7b5, mon_a, mon_e);
         end
      end
   end

   initial begin
      exp_t e;
      bus.op = cur_op; bus.funct3 = cur_f3; bus.funct7b5 = cur_f7;
      bus.mem_ready = 1'b0; bus.zero = 1'b0;
      // Reset cycle in FETCH: selects are visible, but the strobes are held low.
      e = base(); e.sb = 2'b10; e.rs = 2'b10;
      step(e, 1'b1, 1'b0, 1'b1);

      run_instr(K_R, 0, 0);
      run_instr(K_LW, 0, 2);
      run_instr(K_SW, 0, 3);
      run_instr(K_BEQ, 0, 0);
      run_instr(K_JAL, 1, 0);
      for (int i = 0; i < 80; i++)
         run_instr(kind_e'($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 3));

      // Unsupported opcode: trap in ILLEGAL with a sticky flag, then clear it with reset.
      cur_op = 7'b1110011; cur_f3 = 3'($urandom); cur_f7 = rb();
      fetch(0);
      e = base(); e.sa = 2'b01; e.sb = 2'b01;
      step(e, rb(), rb(), 1'b0);
      e = base();
      step(e, rb(), rb(), 1'b0);
      ill_exp = 1'b1;
      repeat (4) begin
         e = base();
         step(e, rb(), rb(), 1'b0);
      end
      e = base();
      step(e, 1'b1, rb(), 1'b1);
      ill_exp = 1'b0;
      run_instr(K_I, 0, 0);

      // Reset in the middle of a store: MemWrite must drop in the reset cycle.
      cur_op = 7'b0100011; cur_f3 = 3'b010; cur_f7 = 1'b0;
      fetch(0);
      e = base(); e.sa = 2'b01; e.sb = 2'b01;
      step(e, rb(), rb(), 1'b0);
      mem_adr();
      e = base(); e.adr = 1'b1; e.mw = 1'b1;
      step(e, 1'b0, rb(), 1'b0);
      e.mw = 1'b0;
      step(e, 1'b1, rb(), 1'b1);
      run_instr(K_R, 0, 0);

      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0 entries left", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
